threshold_pack_buffer: RTL and testbench

//  Downstream stage of the threshold/compress unit. Collects encoded ternary bytes
//  (5 trits/byte) as each compression register fills, and packs them little-endian

---
 rtl/threshold_pack_buffer.sv | 186 ++++++++++++++++++
 tb/tb_threshold_pack_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_pack_buffer.sv
// threshold_pack_buffer
//   Collects encoded ternary bytes from the compress stage and packs them
//   little-endian into words. Lane k of a word holds the k-th byte accepted
//   into that word. Completed words go into a small in-order FIFO and are
//   offered downstream over a valid/ready handshake. A flush closes a partial
//   word early; its byte-enable mask marks the filled lanes, and unused lanes
//   read 0.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low
//   clear_i      synchronous clear of all state (aborts the current layer)
//   in_valid_i   encoded byte valid
//   in_ready_o   byte accepted when in_valid_i && in_ready_o
//   in_data_i    encoded ternary byte
//   flush_i      close the current partial word (single-cycle pulse)
//   out_valid_o  FIFO head valid
//   out_ready_i  consumer takes the head when out_valid_o && out_ready_i
//   out_data_o   packed word (zero while out_valid_o = 0)
//   out_be_o     byte enables, contiguous from lane 0 (zero while invalid)
//   out_last_o   word was closed by a flush (zero while invalid)
module threshold_pack_buffer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [7:0]                  in_data_i,
    input  logic                        flush_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [8*BYTES_PER_WORD-1:0] out_data_o,
    output logic [BYTES_PER_WORD-1:0]   out_be_o,
    output logic                        out_last_o
);

    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {RUN, FLUSH_WAIT} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt_q;
    logic [W-1:0]              asm_q;

    logic [W-1:0]              mem_data [FIFO_DEPTH];
    logic [BYTES_PER_WORD-1:0] mem_be   [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr;
    logic [NW-1:0]             fill;

    logic                      fifo_full;
    logic                      cnt_last;
    logic                      accept;
    logic                      pop;

    logic                      push;
    logic [W-1:0]              push_data;
    logic [BYTES_PER_WORD-1:0] push_be;
    logic                      push_last;
    logic [W-1:0]              asm_ins;
    int                        filled;
    state_t                    nxt_state;
    logic [CW-1:0]             nxt_cnt;
    logic [W-1:0]              nxt_asm;

    // Lanes 0..n-1 enabled; n == BYTES_PER_WORD gives all ones.
    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input int n);
        logic [BYTES_PER_WORD-1:0] m;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            m[k] = (k < n);
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full   = (fill == NW'(FIFO_DEPTH));
    assign cnt_last    = (cnt_q == CW'(BYTES_PER_WORD - 1));
    // Depends only on registered state, so out_ready_i never reaches in_ready_o
    // and a same-cycle pop cannot make room for a push.
    assign in_ready_o  = (state == RUN) && (!cnt_last || !fifo_full);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (fill != '0);
    assign pop         = out_valid_o && out_ready_i;

    assign out_data_o  = out_valid_o ? mem_data[rd_ptr] : '0;
    assign out_be_o    = out_valid_o ? mem_be[rd_ptr]   : '0;
    assign out_last_o  = out_valid_o ? mem_last[rd_ptr] : 1'b0;

    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (accept && (cnt_q == CW'(k))) asm_ins[8*k +: 8] = in_data_i;
        end
        // Lanes holding data once this cycle's byte (if any) is included.
        filled    = int'(cnt_q) + (accept ? 1 : 0);
        push      = 1'b0;
        push_data = asm_ins;
        push_be   = lane_mask(filled);
        push_last = 1'b0;
        nxt_state = state;
        nxt_cnt   = cnt_q;
        nxt_asm   = asm_q;
        case (state)
            RUN: begin
                if (accept && cnt_last) begin
                    // Word completed; a flush in the same cycle only marks it last.
                    push      = 1'b1;
                    push_last = flush_i;
                    nxt_cnt   = '0;
                    nxt_asm   = '0;
                end else if (flush_i && (filled != 0)) begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                        nxt_cnt   = '0;
                        nxt_asm   = '0;
                    end else begin
                        // Hold the partial word (incl. this cycle's byte) until space frees.
                        nxt_state = FLUSH_WAIT;
                        nxt_cnt   = accept ? cnt_q + CW'(1) : cnt_q;
                        nxt_asm   = asm_ins;
                    end
                end else if (accept) begin
                    nxt_cnt = cnt_q + CW'(1);
                    nxt_asm = asm_ins;
                end
            end
            FLUSH_WAIT: begin
                push_last = 1'b1;
                if (!fifo_full) begin
                    push      = 1'b1;
                    nxt_cnt   = '0;
                    nxt_asm   = '0;
                    nxt_state = RUN;
                end
            end
            default: nxt_state = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= RUN;
            cnt_q  <= '0;
            asm_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_be[i]   <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (clear_i) begin
            state  <= RUN;
            cnt_q  <= '0;
            asm_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            state <= nxt_state;
            cnt_q <= nxt_cnt;
            asm_q <= nxt_asm;
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_be[wr_ptr]   <= push_be;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fill <= fill + NW'(push) - NW'(pop);
        end
    end

endmodule

// File: tb/tb_threshold_pack_buffer.sv
module tb_threshold_pack_buffer;

    localparam int BPW   = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_last;

    always #5 clk = ~clk;

    threshold_pack_buffer #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_be_o   (out_be),
        .out_last_o (out_last)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  be;
        logic        last;
    } word_t;

    // Reference model: pending bytes of the open word, queue of finished words,
    // and whether a flushed word is waiting for FIFO space.
    word_t      q[$];
    logic [7:0] pend[$];
    bit         waiting;
    bit         acc_last;
    int         n_checks;
    int         n_fail;

    function automatic word_t make_word(input bit last);
        word_t w;
        w = '0;
        foreach (pend[k]) begin
            w.d     = w.d | (32'(pend[k]) << (8 * k));
            w.be[k] = 1'b1;
        end
        w.last = last;
        return w;
    endfunction

    function automatic bit exp_ready();
        return !waiting && ((pend.size() != BPW - 1) || (q.size() < DEPTH));
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        word_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready",  32'(in_ready),  32'(exp_ready()));
        check("out_data",  out_data,       h.d);
        check("out_be",    32'(out_be),    32'(h.be));
        check("out_last",  32'(out_last),  32'(h.last));
    endtask

    task automatic model_update(input bit v, input logic [7:0] d, input bit f,
                                input bit r, input bit c);
        bit full, pop, rdy;
        rdy      = exp_ready();
        acc_last = 1'b0;
        if (c) begin
            q.delete();
            pend.delete();
            waiting = 1'b0;
            return;
        end
        full = (q.size() >= DEPTH);
        pop  = (q.size() > 0) && r;
        if (waiting) begin
            if (!full) begin
                q.push_back(make_word(1'b1));
                pend.delete();
                waiting = 1'b0;
            end
        end else begin
            if (v && rdy) begin
                pend.push_back(d);
                acc_last = 1'b1;
            end
            if (pend.size() == BPW) begin
                q.push_back(make_word(f));
                pend.delete();
            end else if (f && pend.size() > 0) begin
                if (!full) begin
                    q.push_back(make_word(1'b1));
                    pend.delete();
                end else begin
                    waiting = 1'b1;
                end
            end
        end
        if (pop) q.delete(0);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f,
                        input bit r, input bit c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        clear     = c;
        #1;
        check_outputs();
        model_update(v, d, f, r, c);
    endtask

    task automatic send(input logic [7:0] b, input bit f, input bit r);
        for (int t = 0; t < 20; t++) begin
            step(1'b1, b, f, r, 1'b0);
            if (acc_last) break;
        end
        check("send_accepted", 32'(acc_last), 32'd1);
    endtask

    task automatic idle(input int n, input bit r);
        for (int t = 0; t < n; t++) step(1'b0, 8'h00, 1'b0, r, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        clear    = 1'b0;
        #1;
        q.delete();
        pend.delete();
        waiting = 1'b0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        waiting   = 1'b0;
        acc_last  = 1'b0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two full words with a ready consumer.
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
        idle(1, 1'b1);
        check("t1_word2", out_data, 32'h08070605);
        idle(2, 1'b1);

        // Partial word closed by flush, then a flush with nothing pending.
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b0, 1'b1);
        send(8'hCC, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("t2_data", out_data, 32'h00CCBBAA);
        check("t2_be",   32'(out_be), 32'h7);
        idle(1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Backpressure: FIFO fills, 4th byte of word 3 stalls until one pop.
        for (int i = 1; i <= 11; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Flush while FIFO full with one pending byte.
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 1'b0, 1'b0);
        send(8'h51, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Byte at lane 3 with a same-cycle flush.
        send(8'h41, 1'b0, 1'b1);
        send(8'h42, 1'b0, 1'b1);
        send(8'h43, 1'b0, 1'b1);
        send(8'h44, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("t5_data", out_data, 32'h44434241);
        check("t5_last", 32'(out_last), 32'd1);
        idle(3, 1'b1);

        // Clear with queued words and pending bytes.
        for (int i = 0; i < 10; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'h70 + i), 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset in the middle of a word with a queued word.
        for (int i = 0; i < 6; i++) send(8'(8'h80 + i), 1'b0, 1'b0);
        do_reset();
        idle(2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
        end
        idle(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
